// File: rtl/aes_key_expander.sv
// AES-128/192/256 key-schedule engine: streams the expanded schedule one 32-bit
// word per valid/ready transfer, with rcon kept in a register advanced by xtime.
module aes_key_expander #(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [32*MAX_NK-1:0] key_in,
  input  logic                 rk_ready,
  output logic                 rk_valid,
  output logic [31:0]          rk_word,
  output logic [5:0]           rk_index,
  output logic [7:0]           rcon_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  state_t      state, state_nx;
  logic [31:0] win [MAX_NK];
  logic [31:0] win_nx [MAX_NK];
  logic [2:0]  mod_cnt, mod_cnt_nx;
  logic [2:0]  nk_m1, nk_m1_nx;
  logic [5:0]  nw_last, nw_last_nx;
  logic        rk_valid_nx, busy_nx, done_nx, err_nx;
  logic [31:0] rk_word_nx;
  logic [5:0]  rk_index_nx;
  logic [7:0]  rcon_nx;

  logic [2:0]  nk_m1_sel;
  logic [5:0]  nw_last_sel;
  logic        legal;
  logic [5:0]  nxt_idx;
  logic        key_phase;
  logic [31:0] key_pick, temp, gen_word, nxt_word;

  // Decode requested key size and reject sizes this instance cannot hold.
  always_comb begin
    nk_m1_sel   = 3'd3;
    nw_last_sel = 6'd43;
    case (key_len)
      2'd0: begin nk_m1_sel = 3'd3; nw_last_sel = 6'd43; end
      2'd1: begin nk_m1_sel = 3'd5; nw_last_sel = 6'd51; end
      2'd2: begin nk_m1_sel = 3'd7; nw_last_sel = 6'd59; end
      default: begin nk_m1_sel = 3'd3; nw_last_sel = 6'd43; end
    endcase
    legal = (key_len != 2'd3) && (({1'b0, nk_m1_sel} + 4'd1) <= 4'(MAX_NK));
  end

  // Next schedule word. The window holds w[i-Nk+1..i]; during the key phase
  // it is static and simply holds the cipher key.
  always_comb begin
    nxt_idx   = rk_index + 6'd1;
    key_phase = (nxt_idx <= {3'b000, nk_m1});
    key_pick  = 32'h0000_0000;
    for (int k = 0; k < MAX_NK; k++) begin
      if (nxt_idx == 6'(k)) key_pick = win[k];
      else                  key_pick = key_pick;
    end
    if (mod_cnt == 3'd0)                          temp = sub_word(rot_word(rk_word)) ^ {rcon_out, 24'h000000};
    else if (nk_m1 == 3'd7 && mod_cnt == 3'd4)    temp = sub_word(rk_word);
    else                                          temp = rk_word;
    gen_word = win[0] ^ temp;
    nxt_word = key_phase ? key_pick : gen_word;
  end

  // FSM next-state and registered-output next values.
  always_comb begin
    state_nx    = state;
    win_nx      = win;
    mod_cnt_nx  = mod_cnt;
    nk_m1_nx    = nk_m1;
    nw_last_nx  = nw_last;
    rk_valid_nx = rk_valid;
    rk_word_nx  = rk_word;
    rk_index_nx = rk_index;
    rcon_nx     = rcon_out;
    busy_nx     = busy;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (start && legal) begin
          state_nx    = LOAD;
          busy_nx     = 1'b1;
          rcon_nx     = 8'h01;
          rk_index_nx = 6'd0;
          mod_cnt_nx  = 3'd1;
          nk_m1_nx    = nk_m1_sel;
          nw_last_nx  = nw_last_sel;
          for (int k = 0; k < MAX_NK; k++) begin
            win_nx[k] = key_in[32*(MAX_NK-k)-1 -: 32];
          end
        end else if (start) begin
          err_nx = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        state_nx    = RUN;
        rk_valid_nx = 1'b1;
        rk_word_nx  = win[0];
        rk_index_nx = 6'd0;
      end
      RUN: begin
        if (rk_valid && rk_ready) begin
          if (rk_index == nw_last) begin
            state_nx    = DONE;
            rk_valid_nx = 1'b0;
            busy_nx     = 1'b0;
            done_nx     = 1'b1;
          end else begin
            rk_word_nx  = nxt_word;
            rk_index_nx = nxt_idx;
            mod_cnt_nx  = (mod_cnt == nk_m1) ? 3'd0 : mod_cnt + 3'd1;
            if (!key_phase) begin
              for (int k = 0; k < MAX_NK; k++) begin
                if (3'(k) == nk_m1) win_nx[k] = gen_word;
                else                win_nx[k] = win[(k+1) % MAX_NK];
              end
              if (mod_cnt == 3'd0) rcon_nx = xtime(rcon_out);
              else                 rcon_nx = rcon_out;
            end else begin
              win_nx = win;
            end
          end
        end else begin
          state_nx = RUN;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      win      <= '{default: 32'h0000_0000};
      mod_cnt  <= 3'd0;
      nk_m1    <= 3'd3;
      nw_last  <= 6'd43;
      rk_valid <= 1'b0;
      rk_word  <= 32'h0000_0000;
      rk_index <= 6'd0;
      rcon_out <= 8'h01;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      win      <= win_nx;
      mod_cnt  <= mod_cnt_nx;
      nk_m1    <= nk_m1_nx;
      nw_last  <= nw_last_nx;
      rk_valid <= rk_valid_nx;
      rk_word  <= rk_word_nx;
      rk_index <= rk_index_nx;
      rcon_out <= rcon_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: FIPS-197 key vectors, stalls, illegal
// start, mid-run start and mid-run reset.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key_in = '0;
  logic         rk_ready = 1'b1;
  logic         rk_valid;
  logic [31:0]  rk_word;
  logic [5:0]   rk_index;
  logic [7:0]   rcon_out;
  logic         busy, done, err;

  aes_key_expander #(.MAX_NK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_word(rk_word), .rk_index(rk_index),
    .rcon_out(rcon_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] idx; logic [31:0] word; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] got [60];
  logic [31:0] ref_w [60];
  logic [7:0]  rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int checks = 0, errors = 0, cyc = 0;
  int cur_nk = 4, cur_nw = 44;
  int xfer_cnt = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0, err_cnt = 0, stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word = '0;
  logic [5:0]  prev_idx = '0;

  localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
  localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h55aa55aa_33cc33cc};
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Reference S-box: inverse by exhaustive search, then bitwise affine map.
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00; c = 8'h63;
    for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
  endfunction

  task automatic build(input logic [255:0] key, input int nk, input int nw);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) ref_w[i] = key[255-32*i -: 32];
      else begin
        t = ref_w[i-1];
        if (i % nk == 0) begin
          t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = m_mul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) t = m_sub(t);
        ref_w[i] = ref_w[i-nk] ^ t;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every transfer, checks stall stability and rcon.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(rk_valid), 32'd1);
        check("stall_word", rk_word, prev_word);
        check("stall_index", 32'(rk_index), 32'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        idx = int'(rk_index);
        if (sb_q.size() == 0) begin
          check("unexpected_word", 32'(idx), 32'hffff_ffff);
        end else begin
          e = sb_q.pop_front();
          check("sb_index", 32'(rk_index), 32'(e.idx));
          check("sb_word", rk_word, e.word);
        end
        if (idx < 60) got[idx] = rk_word;
        if (xfer_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_cnt++;
        if (((idx + 1) % cur_nk) == 0 && (idx + 1) < cur_nw)
          check("rcon", 32'(rcon_out), 32'(rc_tab[(idx + 1) / cur_nk - 1]));
      end
      if (rk_valid && !rk_ready) stall_cnt++;
      prev_stall = rk_valid && !rk_ready;
      prev_word  = rk_word;
      prev_idx   = rk_index;
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  task automatic run_key(input logic [1:0] kl, input logic [255:0] key, input bit rnd,
                         input int inject_at, input int abort_at);
    int  nk, nw, n;
    bit  finished;
    exp_t e;
    nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
    nw = (kl == 2'd0) ? 44 : (kl == 2'd1) ? 52 : 60;
    build(key, nk, nw);
    sb_q.delete();
    for (int i = 0; i < nw; i++) begin e.idx = 6'(i); e.word = ref_w[i]; sb_q.push_back(e); end
    cur_nk = nk; cur_nw = nw;
    xfer_cnt = 0; done_cnt = 0; err_cnt = 0; stall_cnt = 0;
    @(posedge clk); #1;
    key_len = kl; key_in = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    check("load_valid", 32'(rk_valid), 32'd0);
    @(posedge clk); #1;
    key_in = ~key;
    check("first_valid", 32'(rk_valid), 32'd1);
    check("first_index", 32'(rk_index), 32'd0);
    finished = 1'b0;
    for (n = 0; n < 400 && !finished; n++) begin
      if (abort_at >= 0 && rk_valid && int'(rk_index) == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check("abort_valid", 32'(rk_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rcon", 32'(rcon_out), 32'h01);
        check("abort_index", 32'(rk_index), 32'd0);
        @(posedge clk); #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        return;
      end
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == inject_at) begin start = 1'b1; key_len = 2'd3; end
      else begin start = 1'b0; key_len = kl; end
      @(posedge clk); #1;
      if (done) finished = 1'b1;
    end
    start = 1'b0;
    check("run_finished", 32'(finished), 32'd1);
    if (!finished) sb_q.delete();
    rk_ready = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("xfer_count", 32'(xfer_cnt), 32'(nw));
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_valid", 32'(rk_valid), 32'd0);
    check("no_err_in_run", 32'(err_cnt), 32'd0);
    if (!rnd) check("back_to_back", 32'(last_cyc - first_cyc), 32'(nw - 1));
    else      check("stalls_seen", 32'(stall_cnt > 0), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rk_valid), 32'd0);
    check("rst_word", rk_word, 32'd0);
    check("rst_index", 32'(rk_index), 32'd0);
    check("rst_rcon", 32'(rcon_out), 32'h01);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    run_key(2'd0, K128, 1'b0, 10, -1);
    check("aes128_w4", got[4], 32'ha0fafe17);
    check("aes128_w43", got[43], 32'hb6630ca6);

    run_key(2'd1, K192, 1'b0, -1, -1);
    check("aes192_w6", got[6], 32'hfe0c91f7);
    check("aes192_w51", got[51], 32'h01002202);

    run_key(2'd2, K256, 1'b0, 5, -1);
    check("aes256_w8", got[8], 32'h9ba35411);
    check("aes256_w12", got[12], 32'ha8b09c1a);
    check("aes256_w59", got[59], 32'h706c631e);

    got[43] = 32'h0;
    run_key(2'd0, K128, 1'b1, -1, -1);
    check("aes128_rnd_w43", got[43], 32'hb6630ca6);

    // Illegal key length: err pulse only.
    @(posedge clk); #1;
    key_len = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    check("illegal_valid", 32'(rk_valid), 32'd0);
    @(posedge clk); #1;
    check("illegal_err_pulse", 32'(err), 32'd0);
    check("illegal_stay_idle", 32'(busy), 32'd0);

    run_key(2'd0, K128, 1'b0, -1, 20);
    got[0] = 32'h0; got[4] = 32'h0;
    run_key(2'd0, K128, 1'b0, -1, -1);
    check("after_rst_w0", got[0], 32'h2b7e1516);
    check("after_rst_w4", got[4], 32'ha0fafe17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
